// File: rtl/regfile_scrub.sv
// rtl/regfile_scrub.sv - LEGv8-style register file with XZR, write bypass and post-reset scrub
module regfile_scrub #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 5,
    parameter bit ZERO_EN   = 1'b1,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] readreg_one,
    input  logic [ADDR_W-1:0] readreg_two,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic              clear_req,
    output logic              ready,
    output logic              wr_dropped
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] scrub_idx, scrub_idx_nx;
    logic [DATA_W-1:0] mem [NREG];
    logic              scrub_we;
    logic              wr_accept;
    logic              wr_blocked;

    assign ready      = (state == READY);
    assign scrub_we   = (state == CLEAR) && !clear_req;
    assign wr_accept  = ready && !clear_req && regWrite && !reset
                        && !(ZERO_EN && (writeReg == LAST_IDX));
    // A write during scrub or colliding with a clear request is reported as dropped.
    assign wr_blocked = regWrite && ((state == CLEAR) || clear_req);

    always_comb begin
        state_nx     = state;
        scrub_idx_nx = scrub_idx;
        case (state)
            CLEAR: begin
                if (clear_req) begin
                    scrub_idx_nx = '0;
                end else begin
                    scrub_idx_nx = scrub_idx + 1'b1;
                    if (scrub_idx == LAST_IDX) begin
                        state_nx = READY;
                    end
                end
            end
            READY: begin
                if (clear_req) begin
                    state_nx     = CLEAR;
                    scrub_idx_nx = '0;
                end
            end
            default: begin
                state_nx     = CLEAR;
                scrub_idx_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            scrub_idx  <= '0;
            wr_dropped <= 1'b0;
        end else begin
            state      <= state_nx;
            scrub_idx  <= scrub_idx_nx;
            wr_dropped <= wr_blocked;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (scrub_we) begin
                mem[scrub_idx] <= '0;
            end else if (wr_accept) begin
                mem[writeReg] <= writeData;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] r);
        logic [DATA_W-1:0] d;
        d = '0;
        if (!ready) begin
            d = '0;
        end else if (ZERO_EN && (r == LAST_IDX)) begin
            d = '0;
        end else if (BYPASS_EN && wr_accept && (writeReg == r)) begin
            d = writeData;
        end else begin
            d = mem[r];
        end
        return d;
    endfunction

    always_comb begin
        readData1 = read_port(readreg_one);
        readData2 = read_port(readreg_two);
    end
endmodule

// File: tb/tb_regfile_scrub.sv
// tb/tb_regfile_scrub.sv - randomized bench for regfile_scrub against a behavioural model
module tb_regfile_scrub;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  readreg_one, readreg_two, writeReg;
    logic        regWrite, clear_req;
    logic [63:0] writeData;
    logic [63:0] readData1, readData2, rd1_nb, rd2_nb;
    logic        ready, wr_dropped, ready_nb, drop_nb;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] m_mem [32];
    int          m_left;
    bit          m_drop;

    always #5 clk = ~clk;

    regfile_scrub dut (
        .clk(clk), .reset(reset),
        .readreg_one(readreg_one), .readreg_two(readreg_two),
        .readData1(readData1), .readData2(readData2),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .clear_req(clear_req), .ready(ready), .wr_dropped(wr_dropped)
    );

    regfile_scrub #(.BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .reset(reset),
        .readreg_one(readreg_one), .readreg_two(readreg_two),
        .readData1(rd1_nb), .readData2(rd2_nb),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .clear_req(clear_req), .ready(ready_nb), .wr_dropped(drop_nb)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_accept();
        return (m_left == 0) && !reset && !clear_req && regWrite && (writeReg != 5'd31);
    endfunction

    function automatic logic [63:0] m_read(input logic [4:0] r, input bit bypass);
        if (m_left != 0) return 64'd0;
        if (r == 5'd31) return 64'd0;
        if (bypass && m_accept() && writeReg == r) return writeData;
        return m_mem[r];
    endfunction

    // Model: a file that spends 32 cycles unusable after reset/clear and is all-zero afterwards.
    task automatic m_edge();
        if (reset) begin
            m_left = 32;
            m_drop = 0;
        end else if (clear_req) begin
            m_left = 32;
            m_drop = regWrite;
        end else if (m_left > 0) begin
            m_left--;
            m_drop = regWrite;
            if (m_left == 0) foreach (m_mem[i]) m_mem[i] = 64'd0;
        end else begin
            m_drop = 0;
            if (m_accept()) m_mem[writeReg] = writeData;
        end
    endtask

    task automatic step(input bit rst, input bit clr, input bit we, input logic [4:0] wr,
                        input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        reset = rst; clear_req = clr; regWrite = we; writeReg = wr; writeData = wd;
        readreg_one = r1; readreg_two = r2;
        #1;
        check("ready", 64'(ready), 64'(m_left == 0));
        check("ready_nb", 64'(ready_nb), 64'(m_left == 0));
        check("wr_dropped", 64'(wr_dropped), 64'(m_drop));
        check("wr_dropped_nb", 64'(drop_nb), 64'(m_drop));
        check("rd1", readData1, m_read(r1, 1'b1));
        check("rd2", readData2, m_read(r2, 1'b1));
        check("rd1_nb", rd1_nb, m_read(r1, 1'b0));
        check("rd2_nb", rd2_nb, m_read(r2, 1'b0));
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [4:0] r);
        for (int i = 0; i < n; i++) step(0, 0, 0, 5'd0, 64'd0, r, 5'(i));
    endtask

    initial begin
        foreach (m_mem[i]) m_mem[i] = 64'd0;
        m_left = 32; m_drop = 0;
        reset = 1; clear_req = 0; regWrite = 0; writeReg = 0; writeData = 0;
        readreg_one = 0; readreg_two = 0;
        @(posedge clk);
        @(negedge clk);
        step(1, 0, 0, 5'd0, 64'd0, 5'd0, 5'd0);
        check("ready_after_reset", 64'(ready), 64'd0);

        // Scrub after reset: 31 edges not ready, ready on the 32nd.
        for (int i = 0; i < 31; i++) step(0, 0, 1, 5'(i), 64'hBAD, 5'(i), 5'(31 - i));
        check("ready_before_32", 64'(ready), 64'd0);
        step(0, 0, 0, 5'd0, 64'd0, 5'd0, 5'd0);
        check("ready_at_32", 64'(ready), 64'd1);
        for (int i = 0; i < 32; i++) step(0, 0, 0, 5'd0, 64'd0, 5'(i), 5'(i));

        step(0, 0, 1, 5'd5, 64'hDEAD_BEEF_0000_0001, 5'd5, 5'd5);
        step(0, 0, 0, 5'd0, 64'd0, 5'd5, 5'd5);
        check("x5_port2", readData2, 64'hDEAD_BEEF_0000_0001);
        readreg_one = 5'd7; writeReg = 5'd7; writeData = 64'h1234; regWrite = 1'b1;
        #1 check("bypass_x7", readData1, 64'h1234);
        step(0, 0, 1, 5'd7, 64'h1234, 5'd7, 5'd0);

        step(0, 0, 1, 5'd31, 64'hFFFF, 5'd31, 5'd31);
        step(0, 0, 0, 5'd0, 64'd0, 5'd31, 5'd31);

        step(0, 0, 1, 5'd3, 64'h3, 5'd3, 5'd3);
        step(0, 1, 1, 5'd3, 64'h55, 5'd3, 5'd3);
        check("drop_after_clear", 64'(wr_dropped), 64'd1);
        idle(32, 5'd3);
        check("x3_after_clear", readData1, 64'd0);

        step(1, 0, 0, 5'd0, 64'd0, 5'd0, 5'd0);
        idle(10, 5'd1);
        step(1, 0, 0, 5'd0, 64'd0, 5'd0, 5'd0);
        idle(31, 5'd1);
        check("ready_restart_31", 64'(ready), 64'd0);
        idle(1, 5'd1);
        check("ready_restart_32", 64'(ready), 64'd1);

        step(0, 0, 1, 5'd9, 64'h7, 5'd0, 5'd0);
        step(0, 0, 1, 5'd9, 64'hA, 5'd9, 5'd9);
        step(0, 0, 0, 5'd0, 64'd0, 5'd9, 5'd9);
        check("nb_x9_next", rd1_nb, 64'hA);

        for (int i = 0; i < 3000; i++) begin
            logic [4:0] wr;
            wr = 5'($urandom);
            step(($urandom % 300) == 0, ($urandom % 80) == 0, 1'($urandom),
                 wr, {$urandom, $urandom},
                 ($urandom % 3 == 0) ? wr : 5'($urandom),
                 ($urandom % 3 == 0) ? wr : 5'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/regfile_scrub.md
# regfile_scrub

Parametrised LEGv8-style general-purpose register file for the CPU datapath's operand-preparation stage. It provides two asynchronous read ports, one clocked write port, an optional hard-wired zero register (XZR), and optional write-to-read bypass. A built-in scrub state machine clears every register to zero after reset or on request, and a `ready` output gates the pipeline until scrubbing completes.

## Interface

Parameters:
- `DATA_W`, 64, register data width in bits.
- `ADDR_W`, 5, register index width; register count `NREG = 2**ADDR_W`.
- `ZERO_EN`, 1, when 1, register `NREG-1` is XZR: it always reads 0 and ignores writes.
- `BYPASS_EN`, 1, when 1, a same-cycle write to the read index is forwarded to the read data.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `readreg_one`  in  ADDR_W  read port 1 index (instruction Rn field).
- `readreg_two`  in  ADDR_W  read port 2 index (instruction Rm/Rt field).
- `readData1`  out  DATA_W  read port 1 data, combinational.
- `readData2`  out  DATA_W  read port 2 data, combinational.
- `regWrite`  in  1  write enable.
- `writeReg`  in  ADDR_W  write index.
- `writeData`  in  DATA_W  write data.
- `clear_req`  in  1  single-cycle request to re-scrub all registers.
- `ready`  out  1  1 = file usable; 0 = scrubbing.
- `wr_dropped`  out  1  registered pulse; a requested write was discarded.

## Operation

- State machine states: `CLEAR` and `READY`.
- Reset: state goes to `CLEAR` and `scrub_idx` goes to 0. Outputs: `ready`=0, `wr_dropped`=0, `readData1`/`readData2`=0.
- `CLEAR`, for each cycle with `reset`=0:
  - write `mem[scrub_idx]`=0, then increment `scrub_idx`.
  - after writing index `NREG-1`, go to `READY`. `scrub_idx` wraps to 0.
- `CLEAR` with `clear_req`=1: restart at `scrub_idx`=0.
- `READY` with `clear_req`=1: go to `CLEAR` with `scrub_idx`=0. The clear takes priority over a same-cycle write.
- Writes (in `READY`, `clear_req`=0, `regWrite`=1): `mem[writeReg]` <= `writeData`.
  - Exception: when `ZERO_EN`=1 and `writeReg`=`NREG-1`, the write is discarded silently. This does not count as a drop.
- `wr_dropped` goes to 1 for exactly one cycle following any cycle in which `regWrite`=1 and the write was blocked by `CLEAR` state or `clear_req`.
- Reads, per port with index `r`:
  - If `ready`=0, data = 0.
  - Otherwise, if `ZERO_EN` and `r`=`NREG-1`, data = 0.
  - Otherwise, if `BYPASS_EN`, a write is being accepted this cycle, and `writeReg`=`r`, data = `writeData`.
  - Otherwise, data = `mem[r]`.
- Both ports may read the same index. Both may also match the write index, and both are then bypassed.
- No X propagation: every register holds a defined value once `ready`=1.

## Timing

- Read latency: 0 cycles (combinational from index, and from write inputs when bypassing).
- Write latency: visible via `mem` from the edge after the write cycle. With `BYPASS_EN`=1 it is also visible in the same cycle.
- Scrub duration: `ready` rises on the `NREG`-th rising edge with `reset`=0 after reset or after `clear_req` (32 edges at default).
- `reset` asserted mid-scrub or mid-operation: next edge forces `CLEAR`, `scrub_idx`=0, `wr_dropped`=0. Register contents need not be cleared in that cycle; the scrub guarantees zeros.
- `clear_req` held high: scrub restarts every cycle and `ready` stays 0.
- `wr_dropped` is registered: it is high in the cycle after the blocked write.

## Test plan

- Reset 1 cycle, then idle → `ready`=0 for 31 edges and 1 at edge 32. All 32 indices read 0.
- After ready, write X5=`64'hDEAD_BEEF_0000_0001`, then read ports 1 and 2 at index 5 → both return the value. Same-cycle bypass: `readreg_one`=`writeReg`=7 with data `64'h1234` → `readData1`=`64'h1234` in the write cycle.
- Write index 31 with `64'hFFFF` (`ZERO_EN`=1) → reads of 31 return 0 in the same and next cycle. `wr_dropped` stays 0.
- `clear_req` in the same cycle as a write to X3=`64'h55` → `wr_dropped`=1 next cycle, `ready`=0 for 32 edges, X3 then reads 0.
- Reset pulsed at `scrub_idx`=10 → scrub restarts from 0. `ready` rises exactly 32 edges after reset deasserts.
- `BYPASS_EN`=0 with the write to X9=`64'hA` while reading X9 → old value this cycle, `64'hA` next cycle.
